// File: rtl/pipe_shifter_if.sv
// rtl/pipe_shifter_if.sv - request/response handshake bundle for pipe_shifter
interface pipe_shifter_if #(
    parameter int OPERAND_WIDTH = 16,
    parameter int SHAMT_WIDTH   = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [OPERAND_WIDTH-1:0] InBS;
    logic [SHAMT_WIDTH-1:0]   ShAmt;
    logic [2:0]               ShiftOper;
    logic                     out_valid;
    logic                     out_ready;
    logic [OPERAND_WIDTH-1:0] OutBS;
    logic                     out_zero;
    logic                     CarryOut;

    modport master (
        output in_valid, InBS, ShAmt, ShiftOper, out_ready,
        input  in_ready, out_valid, OutBS, out_zero, CarryOut
    );

    modport slave (
        input  in_valid, InBS, ShAmt, ShiftOper, out_ready,
        output in_ready, out_valid, OutBS, out_zero, CarryOut
    );
endinterface

// File: rtl/pipe_shifter.sv
// rtl/pipe_shifter.sv - pipelined barrel shifter (SLL/SRL/ROL/ROR/SRA) with valid/ready flow control
// Optional last-shifted-out carry output built only when SHIFTER_CARRY_EN is defined.
module pipe_shifter #(
    parameter int OPERAND_WIDTH = 16,
    parameter int SHAMT_WIDTH   = 4,
    parameter int PIPE_STAGES   = 2
) (
    input  logic           clk,
    input  logic           rst,
    pipe_shifter_if.slave  bus
);
    localparam int W = OPERAND_WIDTH;
    localparam int S = SHAMT_WIDTH;
    localparam int P = PIPE_STAGES;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_ROL = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;

    logic         r_vld  [P];
    logic [W-1:0] r_data [P];
    logic [2:0]   r_op   [P];
    logic [S-1:0] r_amt  [P];

    logic         w_src_v   [P];
    logic [W-1:0] w_src_d   [P];
    logic [2:0]   w_src_op  [P];
    logic [S-1:0] w_src_amt [P];
    logic [W-1:0] w_nx_d    [P];
    logic [P-1:0] w_load;
    logic         w_all_full;

    function automatic logic [W-1:0] shift_level(input logic [W-1:0] d, input logic [2:0] op,
                                                 input int k);
        case (op)
            OP_SLL:  return d << k;
            OP_SRL:  return d >> k;
            OP_ROL:  return (d << k) | (d >> (W - k));
            OP_ROR:  return (d >> k) | (d << (W - k));
            OP_SRA:  return $signed(d) >>> k;
            default: return d;
        endcase
    endfunction

`ifdef SHIFTER_CARRY_EN
    logic r_cy     [P];
    logic w_src_cy [P];
    logic w_nx_cy  [P];

    // Bit that leaves the word last at this level; cascading keeps the final level's value.
    function automatic logic carry_level(input logic [W-1:0] d, input logic [2:0] op, input int k);
        logic [W-1:0] t;
        t = '0;
        case (op)
            OP_SLL:         t = d >> (W - k);
            OP_SRL, OP_SRA: t = d >> (k - 1);
            default:        t = '0;
        endcase
        return t[0];
    endfunction
`endif

    always_comb begin
        w_src_v[0]   = bus.in_valid;
        w_src_d[0]   = bus.InBS;
        w_src_op[0]  = bus.ShiftOper;
        w_src_amt[0] = bus.ShAmt;
`ifdef SHIFTER_CARRY_EN
        w_src_cy[0]  = 1'b0;
`endif
        for (int n = 1; n < P; n++) begin
            w_src_v[n]   = r_vld[n-1];
            w_src_d[n]   = r_data[n-1];
            w_src_op[n]  = r_op[n-1];
            w_src_amt[n] = r_amt[n-1];
`ifdef SHIFTER_CARRY_EN
            w_src_cy[n]  = r_cy[n-1];
`endif
        end
    end

    // Level i (shift by 2^i) is evaluated in front of register stage floor(i*P/S).
    always_comb begin
        for (int n = 0; n < P; n++) begin
            w_nx_d[n] = w_src_d[n];
`ifdef SHIFTER_CARRY_EN
            w_nx_cy[n] = w_src_cy[n];
`endif
            for (int i = 0; i < S; i++) begin
                if (((i * P) / S) == n && w_src_amt[n][i]) begin
`ifdef SHIFTER_CARRY_EN
                    w_nx_cy[n] = carry_level(w_nx_d[n], w_src_op[n], 1 << i);
`endif
                    w_nx_d[n] = shift_level(w_nx_d[n], w_src_op[n], 1 << i);
                end
            end
        end
    end

    // A stage may load unless it and every stage after it are full with the output stalled.
    always_comb begin
        w_all_full = 1'b1;
        w_load     = '0;
        for (int n = P - 1; n >= 0; n--) begin
            w_all_full = w_all_full & r_vld[n];
            w_load[n]  = bus.out_ready || !w_all_full;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < P; n++) begin
                r_vld[n]  <= 1'b0;
                r_data[n] <= '0;
                r_op[n]   <= '0;
                r_amt[n]  <= '0;
`ifdef SHIFTER_CARRY_EN
                r_cy[n]   <= 1'b0;
`endif
            end
        end else begin
            for (int n = 0; n < P; n++) begin
                if (w_load[n]) begin
                    r_vld[n] <= w_src_v[n];
                    if (w_src_v[n]) begin
                        r_data[n] <= w_nx_d[n];
                        r_op[n]   <= w_src_op[n];
                        r_amt[n]  <= w_src_amt[n];
`ifdef SHIFTER_CARRY_EN
                        r_cy[n]   <= w_nx_cy[n];
`endif
                    end
                end
            end
        end
    end

    assign bus.in_ready  = w_load[0];
    assign bus.out_valid = r_vld[P-1];
    assign bus.OutBS     = r_data[P-1];
    assign bus.out_zero  = r_vld[P-1] && (r_data[P-1] == '0);
`ifdef SHIFTER_CARRY_EN
    assign bus.CarryOut  = r_cy[P-1];
`else
    assign bus.CarryOut  = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_shifter.sv
// tb/tb_pipe_shifter.sv - scoreboard bench for pipe_shifter with directed vectors
module tb_pipe_shifter;
    localparam int W = 16;
    localparam int S = 4;
    localparam int P = 2;
`ifdef SHIFTER_CARRY_EN
    localparam bit CARRY_ON = 1'b1;
`else
    localparam bit CARRY_ON = 1'b0;
`endif

    localparam logic [2:0] SLL = 3'b000;
    localparam logic [2:0] SRL = 3'b001;
    localparam logic [2:0] ROL = 3'b010;
    localparam logic [2:0] ROR = 3'b011;
    localparam logic [2:0] SRA = 3'b100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_shifter_if #(.OPERAND_WIDTH(W), .SHAMT_WIDTH(S)) bus ();

    pipe_shifter #(.OPERAND_WIDTH(W), .SHAMT_WIDTH(S), .PIPE_STAGES(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        z;
        logic        cy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [15:0] ed, input logic ecy);
        exp_t e;
        e.d  = ed;
        e.z  = (ed == 16'h0000);
        e.cy = CARRY_ON & ecy;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [15:0] d, input logic [3:0] amt, input logic [2:0] op);
        bus.in_valid  = 1'b1;
        bus.InBS      = d;
        bus.ShAmt     = amt;
        bus.ShiftOper = op;
    endtask

    task automatic idle(input logic ordy);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = ordy;
        bus.InBS      = 16'($urandom());
        bus.ShAmt     = 4'($urandom());
        bus.ShiftOper = 3'($urandom());
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] amt, input logic [2:0] op,
                        input logic [15:0] ed, input logic ecy, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        drive(d, amt, op);
        #1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept_within_bound", 32'(bus.in_ready), 32'(1'b1));
        if (bus.in_ready && push) push_exp(ed, ecy);
    endtask

    // Monitor: every output transfer is matched against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got OutBS=%h with nothing expected at %0t",
                             bus.OutBS, $time);
                end else begin
                    e = sb.pop_front();
                    chk("OutBS", 32'(bus.OutBS), 32'(e.d));
                    chk("out_zero", 32'(bus.out_zero), 32'(e.z));
                    chk("CarryOut", 32'(bus.CarryOut), 32'(e.cy));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got %0d checks expected completion", checks);
        $fatal(1);
    end

    initial begin
        int acc;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.InBS      = '0;
        bus.ShAmt     = '0;
        bus.ShiftOper = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'(1'b0));
        chk("rst_OutBS", 32'(bus.OutBS), 32'(16'h0000));
        chk("rst_out_zero", 32'(bus.out_zero), 32'(1'b0));
        chk("rst_CarryOut", 32'(bus.CarryOut), 32'(1'b0));
        chk("rst_in_ready", 32'(bus.in_ready), 32'(1'b1));

        // Latency: result visible exactly two cycles after the accept cycle.
        send(16'h0001, 4'd15, SLL, 16'h8000, 1'b0, 1'b1);
        idle(1'b1);
        chk("latency_c1_out_valid", 32'(bus.out_valid), 32'(1'b0));
        idle(1'b1);
        chk("latency_c2_out_valid", 32'(bus.out_valid), 32'(1'b1));
        repeat (3) idle(1'b1);

        send(16'h1234, 4'd8,  ROR,    16'h3412, 1'b0, 1'b1);
        send(16'h8001, 4'd1,  ROL,    16'h0003, 1'b0, 1'b1);
        send(16'h8000, 4'd15, SRA,    16'hFFFF, 1'b0, 1'b1);
        send(16'h8000, 4'd15, SRL,    16'h0001, 1'b0, 1'b1);
        send(16'h00F0, 4'd12, SLL,    16'h0000, 1'b1, 1'b1);
        send(16'hBEEF, 4'd7,  3'b110, 16'hBEEF, 1'b0, 1'b1);
        send(16'h8001, 4'd0,  SRA,    16'h8001, 1'b0, 1'b1);
        repeat (4) idle(1'b1);

        // Four back-to-back accepts produce four consecutive results.
        send(16'hA5A5, 4'd4, SLL, 16'h5A50, 1'b0, 1'b1);
        send(16'hA5A5, 4'd4, SRL, 16'h0A5A, 1'b0, 1'b1);
        send(16'hA5A5, 4'd4, ROL, 16'h5A5A, 1'b0, 1'b1);
        send(16'hA5A5, 4'd4, SRA, 16'hFA5A, 1'b0, 1'b1);
        idle(1'b1);
        chk("burst_valid_3", 32'(bus.out_valid), 32'(1'b1));
        idle(1'b1);
        chk("burst_valid_4", 32'(bus.out_valid), 32'(1'b1));
        idle(1'b1);
        chk("burst_done", 32'(bus.out_valid), 32'(1'b0));
        repeat (2) idle(1'b1);

        // Backpressure: pipe fills with exactly two requests, output holds.
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            if (acc == 0)      drive(16'h8000, 4'd15, SRL);
            else if (acc == 1) drive(16'h00FF, 4'd4, ROR);
            else               drive(16'h0F0F, 4'd2, SLL);
            #1;
            if (bus.in_ready) begin
                if (acc == 0)      push_exp(16'h0001, 1'b0);
                else if (acc == 1) push_exp(16'hF00F, 1'b0);
                else               push_exp(16'h3C3C, 1'b0);
                acc++;
            end
        end
        chk("bp_accepts", 32'(acc), 32'(2));
        chk("bp_in_ready", 32'(bus.in_ready), 32'(1'b0));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("bp_hold_valid", 32'(bus.out_valid), 32'(1'b1));
            chk("bp_hold_OutBS", 32'(bus.OutBS), 32'(16'h0001));
        end
        repeat (4) idle(1'b1);
        chk("bp_drained", 32'(sb.size()), 32'(0));

        // Reset with two requests in flight discards both.
        idle(1'b0);
        send(16'h1111, 4'd1, SLL, 16'h2222, 1'b0, 1'b0);
        send(16'h2222, 4'd1, SLL, 16'h4444, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'(1'b0));
        chk("midrst_in_ready", 32'(bus.in_ready), 32'(1'b1));
        idle(1'b1);
        send(16'h8001, 4'd1, SLL, 16'h0002, 1'b1, 1'b1);
        idle(1'b1);
        chk("post_rst_c1_valid", 32'(bus.out_valid), 32'(1'b0));
        idle(1'b1);
        chk("post_rst_c2_valid", 32'(bus.out_valid), 32'(1'b1));
        repeat (2) idle(1'b1);

        // Carry-out cases.
        send(16'h0003, 4'd1, SRA, 16'h0001, 1'b1, 1'b1);
        send(16'h00FF, 4'd4, ROR, 16'hF00F, 1'b0, 1'b1);
        send(16'h0010, 4'd5, SRL, 16'h0000, 1'b1, 1'b1);
        send(16'h8000, 4'd1, SLL, 16'h0000, 1'b1, 1'b1);

        repeat (6) idle(1'b1);
        chk("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_shifter.md
Name: pipe_shifter

Overview:
Parametrised, pipelined successor to the single-cycle 16-bit barrel shifter used by the demo1 ALU.
- Adds arithmetic shift right and a zero flag.
- Width and pipeline depth are configurable.
- Uses a valid/ready handshake so it can sit in an execute-stage functional-unit slot with stalls.

Parameters:
OPERAND_WIDTH, 16, data width; power of 2, ≥4.
SHAMT_WIDTH, 4, shift-amount width; must equal log2(OPERAND_WIDTH).
PIPE_STAGES, 2, number of register stages, 1..SHAMT_WIDTH.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
in_valid  in  1  request valid.
in_ready  out  1  block can accept a request this cycle.
InBS  in  OPERAND_WIDTH  operand.
ShAmt  in  SHAMT_WIDTH  shift/rotate amount, unsigned.
ShiftOper  in  3  000 SLL, 001 SRL, 010 ROL, 011 ROR, 100 SRA, 101–111 pass-through.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
OutBS  out  OPERAND_WIDTH  result.
out_zero  out  1  OutBS == 0 and out_valid.
CarryOut  out  1  see Optional Feature.

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous, active-high.
- Datapath:
  - SHAMT_WIDTH mux levels; level i shifts by 2^i.
  - Level i sits before register stage floor(i*PIPE_STAGES/SHAMT_WIDTH).
  - Stage PIPE_STAGES-1 drives the outputs.
- Fill rules:
  - SLL and SRL fill with zeros.
  - ROL and ROR wrap bits around.
  - SRA fills with InBS[MSB].
  - ShAmt = 0 returns InBS unchanged for every op.
- Pass-through ops (101–111): OutBS = InBS. They take the same latency and flow through the same handshake.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stage advance: stage n loads when it is empty, or when its contents move to stage n+1 (or out of the block) this cycle.
  - in_ready = !stage0_valid || stage0 advancing. This is combinational from out_ready.
- Latency and throughput:
  - With out_ready held 1, a result appears exactly PIPE_STAGES cycles after acceptance.
  - Throughput is 1 result/cycle.
  - Results stay in order; nothing is lost or duplicated.
- Backpressure:
  - While out_valid && !out_ready: OutBS, out_zero and CarryOut hold stable.
  - Bubbles collapse: upstream stages keep filling until all PIPE_STAGES hold data, then in_ready = 0.
- Simultaneous accept and emit when full: allowed in the same cycle (in_ready = 1 when out_ready = 1).
- Reset:
  - Clears all stage valid bits and stage data to 0.
  - Outputs after reset: out_valid = 0, OutBS = 0, out_zero = 0, CarryOut = 0, in_ready = 1.
  - Reset mid-operation discards in-flight requests; no stale result is ever presented.
- Inputs are ignored when in_valid = 0. X on InBS/ShAmt/ShiftOper while in_valid = 0 must not propagate to out_valid.

Optional Feature:
Macro SHIFTER_CARRY_EN.
- Defined: CarryOut is registered with its result.
  - Equals the last bit shifted out: for SLL, InBS[W-ShAmt]; for SRL/SRA, InBS[ShAmt-1].
  - 0 for rotates, pass-through ops and ShAmt = 0.
  - Follows the same hold rules as OutBS.
- Not defined: CarryOut is tied to 0 and no carry logic or flops are built.

Test Plan:
1. Defaults (W=16, PIPE_STAGES=2). Reset, then SLL InBS=0x0001 ShAmt=15, out_ready=1 → out_valid rises 2 cycles after accept, OutBS=0x8000, out_zero=0.
2. ROR 0x1234 ShAmt=8 → 0x3412; ROL 0x8001 ShAmt=1 → 0x0003; SRA 0x8000 ShAmt=15 → 0xFFFF; SRL 0x8000 ShAmt=15 → 0x0001; SLL 0x00F0 ShAmt=12 → 0x0000 with out_zero=1.
3. Four back-to-back accepts (SLL/SRL/ROL/SRA, each on 0xA5A5, ShAmt=4) with out_ready=1 → four results on consecutive cycles, in order: 0x5A50, 0x0A5A, 0x5A5A, 0xFA5A.
4. Backpressure: hold out_ready=0 with in_valid=1 → exactly 2 accepts, then in_ready=0. OutBS stable for 5 cycles. Release → both results drain in order, no duplicates.
5. Assert rst for 1 cycle while 2 requests are in flight → next cycle out_valid=0 and in_ready=1. A fresh request then completes with correct latency and value.
6. With SHIFTER_CARRY_EN: SLL 0x8001 ShAmt=1 → OutBS=0x0002, CarryOut=1; SRA 0x0003 ShAmt=1 → 0x0001, CarryOut=1; ROR any → CarryOut=0. Without the macro → CarryOut always 0.
